rv32_mem_arbiter: RTL
=====================

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum number of consecutive data grants while a fetch waits (legal range 1..15).
REQ-002 The block SHALL have parameter RESP_TIMEOUT, default 64, giving the maximum number of cycles spent in ADDR or RESP before abort (legal range 2..255).
REQ-003 The block SHALL have parameter ERR_DATA, default 32'hDEADBEEF, giving the read data returned on timeout.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 if_req  in  1 / if_addr  in  32  instruction fetch request and word address.
REQ-007 if_rdata  out  32 / if_valid  out  1 / if_stall  out  1  fetch read data, one-cycle completion pulse, and stall.
REQ-008 d_req  in  1 / d_we  in  1 / d_addr  in  32 / d_wdata  in  32  data load/store request.
REQ-009 d_rdata  out  32 / d_valid  out  1 / d_stall  out  1  data read data, one-cycle completion pulse, and stall.
REQ-010 bus_req  out  1 / bus_we  out  1 / bus_addr  out  32 / bus_wdata  out  32  shared single-port memory request.
REQ-011 bus_ready  in  1 / bus_rvalid  in  1 / bus_rdata  in  32  memory accept, read response, and read data.
REQ-012 bus_err  out  1  sticky timeout flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, ADDR and RESP, and SHALL keep owner (IF/D), latched address, latched we and latched wdata in registers.
REQ-014 IDLE SHALL arbitrate as follows: if d_req is high and starve_cnt < STARVE_LIMIT, grant D; else if if_req is high, grant IF; else if d_req is high, grant D; else remain in IDLE.
REQ-015 On a grant, the block SHALL latch the owner's request fields at the clock edge and move to ADDR; a fetch grant SHALL always latch we=0.
REQ-016 In ADDR, bus_req SHALL be 1 and bus_* SHALL be driven from the latched registers only; bus_req SHALL be 0 in IDLE and RESP.
REQ-017 In ADDR, an edge with bus_ready=1 and we=1 SHALL go to IDLE and pulse the owner's valid on the next cycle.
REQ-018 In ADDR, an edge with bus_ready=1 and we=0 SHALL go to RESP.
REQ-019 In RESP, an edge with bus_rvalid=1 SHALL capture bus_rdata into the owner's rdata register, pulse the owner's valid for one cycle, and go to IDLE.
REQ-020 bus_rvalid while not in RESP SHALL be ignored.
REQ-021 Access latency SHALL be a minimum of 2 cycles from request to valid for writes and 3 cycles for reads.
REQ-022 if_rdata and d_rdata SHALL hold their last captured value until the next read completion for that port.
REQ-023 x_stall SHALL equal x_req AND NOT x_valid, combinationally.
REQ-024 Requesters SHALL hold req and fields stable until valid; a request present in the valid cycle SHALL be a new request, arbitrated in that same IDLE cycle.
REQ-025 starve_cnt (4-bit) SHALL increment, saturating at STARVE_LIMIT, on each D grant made while if_req=1, SHALL clear on an IF grant, and SHALL be unchanged on a D grant with if_req=0.
REQ-026 wait_cnt SHALL clear on entry to ADDR and count each cycle spent in ADDR or RESP.
REQ-027 When wait_cnt reaches RESP_TIMEOUT-1 without completion, the FSM SHALL go to IDLE, pulse the owner's valid, load ERR_DATA into the owner's rdata if we=0, and set bus_err.
REQ-028 If completion and timeout occur in the same cycle, completion SHALL win and bus_err SHALL NOT be set.
REQ-029 if_valid and d_valid SHALL never both be 1 in the same cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, owner=IF, starve_cnt=0, wait_cnt=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0 and bus_err=0, including in the middle of an access.
REQ-031 An access aborted by reset SHALL NOT complete, and bus_rvalid arriving after reset release SHALL be ignored.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x100, bus_ready=1, rvalid returned one cycle after accept with 0x00000013 -> if_valid pulses 3 cycles after request, if_rdata=0x00000013, if_stall high for 3 cycles.
REQ-033 Simultaneous: if_req=1 (0x104) and d_req=1, d_we=1 (addr 0x2000, data 0xA5A5A5A5) -> D granted first, bus_we=1, d_valid pulses, then IF granted in the d_valid cycle.
REQ-034 Starvation: d_req held high continuously with if_req=1, STARVE_LIMIT=4 -> exactly 4 D grants, then 1 IF grant, then the counter restarts from 0.
REQ-035 Backpressure: bus_ready=0 for 10 cycles during ADDR -> bus_req and bus_addr stable throughout, no valid pulse, completion only after bus_ready=1.
REQ-036 Timeout: read with bus_rvalid never asserted, RESP_TIMEOUT=64 -> valid pulses with rdata=0xDEADBEEF and bus_err=1 remains set until reset.
REQ-037 Reset mid-read: rst_n=0 while in RESP -> bus_req=0 and all outputs zero immediately; a late bus_rvalid after release produces no valid pulse.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-port memory bus.
// Data has priority, bounded by a fetch starvation counter; every access is guarded by a timeout.
module rv32_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(RESP_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;  // 1 = data port owns the bus
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        err_q, err_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  wait_q, wait_d;

    logic        take_d;
    logic        done;
    logic        timeout;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        err_d      = err_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        take_d     = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // Data wins unless the waiting fetch has already seen STARVE_LIMIT data grants.
                    take_d  = d_req && ((starve_q < STARVE_MAX) || !if_req);
                    state_d = ADDR;
                    wait_d  = 8'd0;
                    owner_d = take_d;
                    addr_d  = take_d ? d_addr : if_addr;
                    we_d    = take_d && d_we;
                    if (take_d) begin
                        wdata_d = d_wdata;
                    end
                    if (!take_d) begin
                        starve_d = 4'd0;
                    end else if (if_req) begin
                        starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
                    end
                end
            end
            ADDR: begin
                if (bus_ready && we_q) begin
                    done = 1'b1;
                end else if (bus_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done = bus_rvalid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == ADDR || state_q == RESP) begin
            // Completion on the last allowed cycle takes precedence over the abort.
            timeout = !done && (wait_q == WAIT_LAST);
            wait_d  = wait_q + 8'd1;
            if (done || timeout) begin
                state_d = IDLE;
                if (owner_q) begin
                    d_valid_d = 1'b1;
                end else begin
                    if_valid_d = 1'b1;
                end
                if (!we_q) begin
                    if (owner_q) begin
                        d_rdata_d = done ? bus_rdata : ERR_DATA;
                    end else begin
                        if_rdata_d = done ? bus_rdata : ERR_DATA;
                    end
                end
                if (timeout) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            starve_q   <= 4'd0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
        end
    end

    assign bus_req   = (state_q == ADDR);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_stall  = if_req && !if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_stall   = d_req && !d_valid_q;

endmodule
